// File: rtl/pio_pkg.sv
// ============================================================================
// Module   : pio_pkg
// Purpose  : Shared widths, delay-field position and fetch state encoding
//            for the PIO state-machine front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pio_pkg;

    localparam int PIO_ADDR_W  = 4;
    localparam int PIO_DATA_W  = 16;
    localparam int PIO_DLY_MSB = 12;
    localparam int PIO_DLY_LSB = 8;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_EXEC  = 2'd1,
        FS_DELAY = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/pio_delay_ctr.sv
// ============================================================================
// Module   : pio_delay_ctr
// Purpose  : Load/decrement down-counter with a "last count" done flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_delay_ctr #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/pio_instr_fetch.sv
// ============================================================================
// Module   : pio_instr_fetch
// Purpose  : PC sequencer / instruction fetch for one PIO state machine.
//            Optional forced-instruction path enabled by PIO_FORCE_INSTR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_instr_fetch
    import pio_pkg::*;
#(
    parameter int ADDR_W  = PIO_ADDR_W,
    parameter int DATA_W  = PIO_DATA_W,
    parameter int DLY_MSB = PIO_DLY_MSB,
    parameter int DLY_LSB = PIO_DLY_LSB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] wrap_bottom,
    input  logic [ADDR_W-1:0] wrap_top,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              stall,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc
`ifdef PIO_FORCE_INSTR_EN
    ,
    input  logic [DATA_W-1:0] force_instr,
    input  logic              force_valid
`endif
);

    localparam int DLY_W = DLY_MSB - DLY_LSB + 1;

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_seq;
    logic [DLY_W-1:0]  dly;
    logic              ctr_clr;
    logic              ctr_load;
    logic              ctr_dec;
    logic [DLY_W-1:0]  ctr_cnt;
    logic              ctr_done;
    logic              force_pend;

`ifdef PIO_FORCE_INSTR_EN
    logic              force_pend_q;
    logic              force_pend_d;
    logic [DATA_W-1:0] force_data_q;
    logic [DATA_W-1:0] force_data_d;

    // A fresh pulse always wins, so back-to-back forces overwrite the pending value.
    always_comb begin
        force_pend_d = force_valid | (force_pend_q & stall);
        force_data_d = force_valid ? force_instr : force_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            force_pend_q <= 1'b0;
            force_data_q <= '0;
        end else begin
            force_pend_q <= force_pend_d;
            force_data_q <= force_data_d;
        end
    end

    assign force_pend = force_pend_q;
`else
    assign force_pend = 1'b0;
`endif

    assign dly       = read_data[DLY_MSB:DLY_LSB];
    assign read_addr = pc_q;
    assign pc        = pc_q;

    assign pc_seq = jmp_valid            ? jmp_addr    :
                    (pc_q == wrap_top)   ? wrap_bottom :
                                           pc_q + ADDR_W'(1);

    pio_delay_ctr #(
        .WIDTH    (DLY_W)
    ) u_delay_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (ctr_clr),
        .load     (ctr_load),
        .load_val (dly),
        .dec      (ctr_dec),
        .cnt      (ctr_cnt),
        .done     (ctr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ctr_clr  = 1'b0;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        if (force_pend) begin
            // Forced instruction owns the cycle; only a jump may move the pc.
            ctr_clr = 1'b1;
            state_d = en ? FS_EXEC : FS_IDLE;
            if (!stall && jmp_valid) begin
                pc_d = jmp_addr;
            end
        end else if (!en) begin
            state_d = FS_IDLE;
            ctr_clr = 1'b1;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    state_d = FS_EXEC;
                end
                FS_EXEC: begin
                    if (!stall) begin
                        pc_d = pc_seq;
                        if (dly != '0) begin
                            ctr_load = 1'b1;
                            state_d  = FS_DELAY;
                        end
                    end
                end
                FS_DELAY: begin
                    ctr_dec = 1'b1;
                    if (ctr_done || (ctr_cnt == '0)) begin
                        state_d = FS_EXEC;
                    end
                end
                default: begin
                    state_d = FS_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
`ifdef PIO_FORCE_INSTR_EN
        if (force_pend_q) begin
            instr_valid = 1'b1;
            instr       = force_data_q;
        end else
`endif
        if (state_q == FS_EXEC) begin
            instr_valid = 1'b1;
            instr       = read_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pio_instr_fetch.sv
// ============================================================================
// Module   : tb_pio_instr_fetch
// Purpose  : Self-checking bench for pio_instr_fetch (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pio_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  wrap_bottom = 4'd0;
    logic [3:0]  wrap_top = 4'd15;
    logic        jmp_valid = 1'b0;
    logic [3:0]  jmp_addr = 4'd0;
    logic        stall = 1'b0;
    logic [3:0]  read_addr;
    logic [15:0] read_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic [3:0]  pc;
`ifdef PIO_FORCE_INSTR_EN
    logic [15:0] force_instr = 16'h0;
    logic        force_valid = 1'b0;
`endif

    logic [15:0] mem [16];
    assign read_data = mem[read_addr];

    always #5 clk = ~clk;

    pio_instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wrap_bottom (wrap_bottom),
        .wrap_top    (wrap_top),
        .jmp_valid   (jmp_valid),
        .jmp_addr    (jmp_addr),
        .stall       (stall),
        .read_addr   (read_addr),
        .read_data   (read_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc)
`ifdef PIO_FORCE_INSTR_EN
        ,
        .force_instr (force_instr),
        .force_valid (force_valid)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: "on" = machine has been enabled long enough to issue,
    // idle_left = idle cycles still owed by the last instruction's delay.
    logic [3:0]  m_pc = 4'd0;
    bit          m_on = 1'b0;
    int          m_idle = 0;
    bit          m_pend = 1'b0;
    logic [15:0] m_fdata = 16'h0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit fv;
        logic [15:0] fd;
        fv = 1'b0;
        fd = 16'h0;
`ifdef PIO_FORCE_INSTR_EN
        fv = force_valid;
        fd = force_instr;
`endif
        if (rst) begin
            m_pc = 4'd0; m_on = 1'b0; m_idle = 0; m_pend = 1'b0; m_fdata = 16'h0;
        end else begin
            if (m_pend) begin
                if (!stall) begin
                    m_pend = 1'b0;
                    if (jmp_valid) m_pc = jmp_addr;
                end
                m_idle = 0;
                m_on   = en;
            end else if (!en) begin
                m_on = 1'b0; m_idle = 0;
            end else if (!m_on) begin
                m_on = 1'b1;
            end else if (m_idle > 0) begin
                m_idle = m_idle - 1;
            end else if (!stall) begin
                m_idle = int'(mem[m_pc][12:8]);
                if (jmp_valid)             m_pc = jmp_addr;
                else if (m_pc == wrap_top) m_pc = wrap_bottom;
                else                       m_pc = 4'((int'(m_pc) + 1) % 16);
            end
            if (fv) begin
                m_pend = 1'b1; m_fdata = fd;
            end
        end
    endtask

    task automatic model_compare();
        bit          ev;
        logic [15:0] ei;
        ev = m_pend || (m_on && m_idle == 0);
        ei = m_pend ? m_fdata : (ev ? mem[m_pc] : 16'h0);
        chk("model_valid", 32'(instr_valid), 32'(ev));
        chk("model_pc",    32'(pc),          32'(m_pc));
        chk("model_instr", 32'(instr),       32'(ei));
        chk("read_addr",   32'(read_addr),   32'(m_pc));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        model_compare();
    endtask

    task automatic expect_out(input string name, input bit v, input logic [3:0] p);
        chk({name, "_valid"}, 32'(instr_valid), 32'(v));
        chk({name, "_pc"},    32'(pc),          32'(p));
    endtask

    typedef struct {
        bit          en;
        bit          exp_valid;
        logic [3:0]  exp_pc;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h00A0 + 16'(i);
        mem[12] = 16'h050C;
        vecs[0] = '{1'b1, 1'b1, 4'd0, 16'h00A0};
        vecs[1] = '{1'b1, 1'b1, 4'd1, 16'h00A1};
        vecs[2] = '{1'b1, 1'b1, 4'd2, 16'h00A2};
        vecs[3] = '{1'b1, 1'b1, 4'd3, 16'h00A3};
        vecs[4] = '{1'b1, 1'b1, 4'd1, 16'h00A1};
        vecs[5] = '{1'b1, 1'b1, 4'd2, 16'h00A2};
        vecs[6] = '{1'b1, 1'b1, 4'd3, 16'h00A3};
        vecs[7] = '{1'b1, 1'b1, 4'd1, 16'h00A1};

        // Reset state
        rst = 1'b1; en = 1'b0;
        tick();
        expect_out("reset", 1'b0, 4'd0);
        chk("reset_instr", 32'(instr), 32'h0);
        rst = 1'b0;

        // Sequential fetch with wrap 3 -> 1
        wrap_top = 4'd3; wrap_bottom = 4'd1;
        for (int i = 0; i < 8; i++) begin
            en = vecs[i].en;
            tick();
            expect_out($sformatf("wrapseq%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
            chk($sformatf("wrapseq%0d_instr", i), 32'(instr), 32'(vecs[i].exp_instr));
        end

        // Delay field of 3 at pc=2
        wrap_top = 4'd15; wrap_bottom = 4'd0;
        mem[2] = 16'h0302;
        tick(); expect_out("dly_issue", 1'b1, 4'd2);
        chk("dly_issue_instr", 32'(instr), 32'h0302);
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out($sformatf("dly_idle%0d", i), 1'b0, 4'd3);
            chk($sformatf("dly_idle%0d_instr", i), 32'(instr), 32'h0);
        end
        tick(); expect_out("dly_resume", 1'b1, 4'd3);

        // Stall holds pc and masks jumps
        jmp_valid = 1'b1; jmp_addr = 4'd5;
        tick(); expect_out("jmp5", 1'b1, 4'd5);
        jmp_valid = 1'b0; stall = 1'b1; jmp_addr = 4'd9;
        for (int i = 0; i < 4; i++) begin
            jmp_valid = (i >= 1 && i <= 2);
            tick(); expect_out($sformatf("stall%0d", i), 1'b1, 4'd5);
        end
        stall = 1'b0; jmp_valid = 1'b1;
        tick(); expect_out("jmp9", 1'b1, 4'd9);

        // 15 -> 0 natural wrap, then wrap_top=0 -> 12
        jmp_addr = 4'd15; wrap_top = 4'd7;
        tick(); expect_out("jmp15", 1'b1, 4'd15);
        jmp_valid = 1'b0;
        tick(); expect_out("pc_rollover", 1'b1, 4'd0);
        wrap_top = 4'd0; wrap_bottom = 4'd12;
        tick(); expect_out("wrap_to_12", 1'b1, 4'd12);
        wrap_top = 4'd15; wrap_bottom = 4'd0;

        // en=0 in the middle of a delay of 5
        tick(); expect_out("dly5_0", 1'b0, 4'd13);
        tick(); expect_out("dly5_1", 1'b0, 4'd13);
        en = 1'b0;
        tick(); expect_out("en_off", 1'b0, 4'd13);
        en = 1'b1;
        tick(); expect_out("en_on", 1'b1, 4'd13);
        tick(); expect_out("no_residual", 1'b1, 4'd14);

`ifdef PIO_FORCE_INSTR_EN
        rst = 1'b1; tick(); rst = 1'b0; en = 1'b0;
        force_valid = 1'b1; force_instr = 16'hE081;
        tick(); expect_out("force_idle", 1'b1, 4'd0);
        chk("force_idle_instr", 32'(instr), 32'hE081);
        force_valid = 1'b0;
        tick(); expect_out("force_done", 1'b0, 4'd0);
        force_valid = 1'b1;
        tick(); expect_out("force_st0", 1'b1, 4'd0);
        force_valid = 1'b0; stall = 1'b1;
        tick(); expect_out("force_st1", 1'b1, 4'd0);
        tick(); expect_out("force_st2", 1'b1, 4'd0);
        chk("force_st2_instr", 32'(instr), 32'hE081);
        stall = 1'b0;
        tick(); expect_out("force_st_done", 1'b0, 4'd0);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 16; i++) begin
            mem[i] = 16'($urandom);
            mem[i][12:8] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 4)) : 5'd0;
        end
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) < 2);
            en        = ($urandom_range(0, 9) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            jmp_valid = ($urandom_range(0, 4) == 0);
            jmp_addr  = 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                wrap_top    = 4'($urandom);
                wrap_bottom = 4'($urandom);
            end
`ifdef PIO_FORCE_INSTR_EN
            force_valid = ($urandom_range(0, 15) == 0);
            force_instr = 16'($urandom);
`endif
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
